per_tx_handshake: RTL and testbench
===================================

PER_TX_HANDSHAKE -- requirements
Module: per_tx_handshake

Interface
REQ-001 Parameter DEPTH, default 4, meaning: FIFO entries; power of two, minimum 2.
REQ-002 Parameter TIMEOUT, default 255, meaning: SEND-state cycles without ack before the error flag sets; range 1..255.
REQ-003 clkPER  input  1  single clock; all state changes on its rising edge.
REQ-004 rstPER  input  1  reset; synchronous, active-low.
REQ-005 inWrEn  input  1  local write strobe; pushes inWrData when high.
REQ-006 inWrData  input  16  word to transmit to the CPU.
REQ-007 outFull  output  1  FIFO holds DEPTH words.
REQ-008 outCount  output  $clog2(DEPTH)+1  words currently buffered.
REQ-009 outSend  output  1  four-phase request to the CPU.
REQ-010 outData  output  16  word offered to the CPU; valid while outSend=1.
REQ-011 inAck  input  1  four-phase acknowledge from the CPU.
REQ-012 outOvf  output  1  sticky flag: a write was dropped because the FIFO was full.
REQ-013 outErr  output  1  sticky flag: ack timeout occurred.
REQ-014 inClrErr  input  1  clears outOvf and outErr.

Function
REQ-015 The block SHALL drive all outputs directly from registers, with no combinational path from any input to any output.
REQ-016 The block SHALL buffer words in a circular FIFO of DEPTH x 16 bits, using read and write pointers that wrap modulo DEPTH.
REQ-017 When inWrEn=1 and the FIFO is not full, the block SHALL store inWrData at the write pointer and increment outCount on that edge.
REQ-018 When inWrEn=1 and the FIFO is full, the block SHALL drop the word, leave the FIFO unchanged and set outOvf.
REQ-019 The FSM SHALL have three states: IDLE (outSend=0), SEND (outSend=1) and RELEASE (outSend=0).
REQ-020 In IDLE with outCount>0 and inAck=0, the block SHALL load the FIFO head into outData and enter SEND on the next edge.
REQ-021 IDLE SHALL NOT start a transfer while inAck=1, so that the return-to-zero phase is guaranteed.
REQ-022 In SEND, outData SHALL remain stable until the FSM leaves SEND.
REQ-023 In SEND, when inAck=1 is sampled, the block SHALL pop the FIFO, enter RELEASE and clear outSend on that same edge.
REQ-024 In RELEASE, when inAck=0 is sampled, the block SHALL enter IDLE.
REQ-025 Latency: a word written into an empty FIFO at edge k SHALL appear with outSend=1 after edge k+1.
REQ-026 Back-to-back transfers: the minimum spacing between two SEND entries SHALL be 3 edges when the ack response is zero-wait.
REQ-027 When a push and a pop fall on the same edge, both SHALL take effect and outCount SHALL be unchanged; a push to a full FIFO coinciding with a pop SHALL be accepted.
REQ-028 The SEND-cycle counter SHALL clear on SEND entry and increment each cycle spent in SEND, saturating at TIMEOUT.
REQ-029 When the SEND-cycle counter reaches TIMEOUT, the block SHALL set outErr and remain in SEND still waiting for ack; the transfer SHALL NOT be aborted.
REQ-030 inClrErr=1 SHALL clear both outOvf and outErr on the next edge; a set event on the same edge SHALL take priority over the clear.
REQ-031 A transition of inAck to 1 in IDLE or RELEASE SHALL be ignored, apart from holding off the start condition of REQ-021.

Reset
REQ-032 While rstPER=0 at a rising edge, the block SHALL force: state IDLE, both pointers 0, outCount=0, outFull=0, outSend=0, outData=16'h0000, outOvf=0, outErr=0, SEND-cycle counter 0.
REQ-033 Reset asserted mid-transfer SHALL drop outSend and discard the FIFO contents, with no pop handshake completed.
REQ-034 FIFO storage contents need not be cleared by reset.

Verification
REQ-035 Single word: write 16'hA5A5 into an empty FIFO, with zero-wait ack -> outSend=1 with outData=A5A5 one edge after the write; outCount returns 0; the FSM passes through SEND, RELEASE, IDLE.
REQ-036 Ordering and back-to-back: write 1,2,3,4 on consecutive cycles -> outFull=1 after the 4th write; words are delivered 1,2,3,4 with SEND entries spaced 3 edges apart.
REQ-037 Overflow: fill the FIFO, then write 16'hDEAD -> outOvf=1 and the word is never transmitted; a simultaneous pop plus write when full is accepted and outCount stays 4.
REQ-038 Timeout: with TIMEOUT=8, hold inAck=0 -> outErr=1 after 8 SEND cycles with outSend still 1; a later ack completes the transfer; inClrErr clears outErr.
REQ-039 Ack held high: keep inAck=1 after a transfer with data pending -> no new SEND until inAck=0 and the FSM returns to IDLE.
REQ-040 Reset mid-SEND: assert rstPER=0 during SEND with 3 words queued -> after the edge outSend=0, outCount=0, outData=0, outOvf=0, outErr=0.

Source files
------------

// File: rtl/per_tx_handshake.sv
// Peripheral-to-CPU transmit path: a 16-bit circular FIFO drained over a
// four-phase send/ack handshake, with sticky overflow and ack-timeout flags.
module per_tx_handshake #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clkPER,
  input  logic                     rstPER,
  input  logic                     inWrEn,
  input  logic [15:0]              inWrData,
  output logic                     outFull,
  output logic [$clog2(DEPTH):0]   outCount,
  output logic                     outSend,
  output logic [15:0]              outData,
  input  logic                     inAck,
  output logic                     outOvf,
  output logic                     outErr,
  input  logic                     inClrErr,
  output logic [1:0]               dbgState
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Handshake: outSend rises with outData stable; the CPU raises inAck to take
  // the word (popped on the edge ack is sampled), then both sides return to zero
  // before IDLE may offer the next word.
  state_t          state, stateNext;
  logic            start, pop, push, ovfSet, errSet;
  logic [CW-1:0]   countNext;
  logic [AW-1:0]   rdPtr, wrPtr;
  logic [7:0]      sendCnt;
  logic [15:0]     mem [DEPTH];

  assign dbgState = state;

  always_comb begin
    stateNext = state;
    start     = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (outCount != '0 && !inAck) begin
          start     = 1'b1;
          stateNext = SEND;
        end
      end
      SEND: begin
        if (inAck) begin
          pop       = 1'b1;
          stateNext = RELEASE;
        end
      end
      RELEASE: begin
        if (!inAck) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
  always_comb begin
    push      = inWrEn && (!outFull || pop);
    ovfSet    = inWrEn && outFull && !pop;
    errSet    = (state == SEND) && !inAck && (sendCnt == TIMEOUT_M1);
    countNext = outCount + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clkPER) begin
    if (!rstPER) state <= IDLE;
    else         state <= stateNext;
  end

  always_ff @(posedge clkPER) begin
    if (!rstPER) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      outCount <= '0;
      outFull  <= 1'b0;
      outSend  <= 1'b0;
      outData  <= 16'h0000;
      outOvf   <= 1'b0;
      outErr   <= 1'b0;
      sendCnt  <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      outCount <= countNext;
      outFull  <= (countNext == CW'(DEPTH));
      outSend  <= (stateNext == SEND);
      if (start) outData <= mem[rdPtr];

      if (start)
        sendCnt <= '0;
      else if (state == SEND && sendCnt != TIMEOUT_C)
        sendCnt <= sendCnt + 8'd1;

      // Set events win over a simultaneous clear.
      if (ovfSet)        outOvf <= 1'b1;
      else if (inClrErr) outOvf <= 1'b0;
      if (errSet)        outErr <= 1'b1;
      else if (inClrErr) outErr <= 1'b0;
    end
  end

  always_ff @(posedge clkPER) begin
    if (push) mem[wrPtr] <= inWrData;
  end

endmodule

// File: tb/tb_per_tx_handshake.sv
// Directed bench for per_tx_handshake (DEPTH=4, TIMEOUT=8): single word,
// ordering/back-to-back, overflow, timeout, held ack and mid-transfer reset.
module tb_per_tx_handshake;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic        clkPER = 1'b0;
  logic        rstPER;
  logic        inWrEn;
  logic [15:0] inWrData;
  logic        outFull;
  logic [2:0]  outCount;
  logic        outSend;
  logic [15:0] outData;
  logic        inAck;
  logic        outOvf;
  logic        outErr;
  logic        inClrErr;
  logic [1:0]  dbgState;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  // clock / reset
  always #5 clkPER = ~clkPER;

  per_tx_handshake #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clkPER   (clkPER),
    .rstPER   (rstPER),
    .inWrEn   (inWrEn),
    .inWrData (inWrData),
    .outFull  (outFull),
    .outCount (outCount),
    .outSend  (outSend),
    .outData  (outData),
    .inAck    (inAck),
    .outOvf   (outOvf),
    .outErr   (outErr),
    .inClrErr (inClrErr),
    .dbgState (dbgState)
  );

  // driver tasks
  task automatic tick();
    @(posedge clkPER);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [15:0] w, input bit accepted);
    inWrEn   = 1'b1;
    inWrData = w;
    tick();
    inWrEn   = 1'b0;
    if (accepted) exp_q.push_back(w);
  endtask

  // Called with the DUT in SEND; completes one zero-wait handshake and, if more
  // words remain, advances exactly to the next SEND entry (3 edges total).
  task automatic serve_one(input string tag);
    logic [15:0] e;
    e = exp_q.pop_front();
    check({tag, "_send"}, outSend, 1'b1);
    check({tag, "_data"}, outData, e);
    inAck = 1'b1;
    tick();
    check({tag, "_rel"}, dbgState, S_RELEASE);
    check({tag, "_send_low"}, outSend, 1'b0);
    inAck = 1'b0;
    tick();
    check({tag, "_idle"}, dbgState, S_IDLE);
    if (exp_q.size() > 0) tick();
  endtask

  initial begin
    rstPER   = 1'b0;
    inWrEn   = 1'b0;
    inWrData = 16'h0000;
    inAck    = 1'b0;
    inClrErr = 1'b0;
    tick();
    tick();
    check("rst_send",  outSend,  1'b0);
    check("rst_count", outCount, 3'd0);
    check("rst_full",  outFull,  1'b0);
    check("rst_data",  outData,  16'h0000);
    check("rst_ovf",   outOvf,   1'b0);
    check("rst_err",   outErr,   1'b0);
    check("rst_state", dbgState, S_IDLE);
    rstPER = 1'b1;
    tick();

    // single word, latency one edge after the write
    write_word(16'hA5A5, 1'b1);
    check("sw_count", outCount, 3'd1);
    check("sw_nosend", outSend, 1'b0);
    tick();
    check("sw_state", dbgState, S_SEND);
    serve_one("sw");
    check("sw_empty", outCount, 3'd0);

    // ordering, full flag, back-to-back spacing
    write_word(16'd1, 1'b1);
    write_word(16'd2, 1'b1);
    write_word(16'd3, 1'b1);
    write_word(16'd4, 1'b1);
    check("b2b_full",  outFull,  1'b1);
    check("b2b_count", outCount, 3'd4);
    for (int i = 0; i < 4; i++) serve_one("b2b");
    check("b2b_empty", outCount, 3'd0);
    check("b2b_notfull", outFull, 1'b0);

    // overflow with simultaneous clear (set wins), then push+pop while full
    write_word(16'h0011, 1'b1);
    write_word(16'h0022, 1'b1);
    write_word(16'h0033, 1'b1);
    write_word(16'h0044, 1'b1);
    inClrErr = 1'b1;
    write_word(16'hDEAD, 1'b0);
    inClrErr = 1'b0;
    check("ovf_flag",  outOvf,   1'b1);
    check("ovf_count", outCount, 3'd4);
    check("ovf_data",  outData,  16'h0011);
    inWrEn   = 1'b1;
    inWrData = 16'h0055;
    inAck    = 1'b1;
    tick();
    void'(exp_q.pop_front());
    exp_q.push_back(16'h0055);
    inWrEn = 1'b0;
    inAck  = 1'b0;
    check("pp_count", outCount, 3'd4);
    check("pp_full",  outFull,  1'b1);
    check("pp_state", dbgState, S_RELEASE);
    check("pp_ovf",   outOvf,   1'b1);
    tick();
    tick();
    for (int i = 0; i < 4; i++) serve_one("drain");
    check("drain_empty", outCount, 3'd0);
    inClrErr = 1'b1;
    tick();
    inClrErr = 1'b0;
    check("ovf_clr", outOvf, 1'b0);

    // ack timeout: error after 8 SEND cycles, transfer not aborted
    write_word(16'hBEEF, 1'b1);
    tick();
    check("to_enter", dbgState, S_SEND);
    for (int i = 0; i < 7; i++) tick();
    check("to_err_early", outErr, 1'b0);
    tick();
    check("to_err",  outErr,  1'b1);
    check("to_send", outSend, 1'b1);
    tick();
    tick();
    check("to_hold_send", outSend, 1'b1);
    check("to_hold_data", outData, 16'hBEEF);
    serve_one("to");
    check("to_err_sticky", outErr, 1'b1);
    inClrErr = 1'b1;
    tick();
    inClrErr = 1'b0;
    check("to_err_clr", outErr, 1'b0);

    // ack held high blocks the next start
    write_word(16'h000A, 1'b1);
    write_word(16'h000B, 1'b1);
    check("ah_send", outData, 16'h000A);
    void'(exp_q.pop_front());
    inAck = 1'b1;
    tick();
    tick();
    tick();
    check("ah_rel_hold", dbgState, S_RELEASE);
    check("ah_rel_send", outSend,  1'b0);
    check("ah_rel_count", outCount, 3'd1);
    inAck = 1'b0;
    tick();
    check("ah_idle", dbgState, S_IDLE);
    inAck = 1'b1;
    tick();
    tick();
    check("ah_idle_hold", dbgState, S_IDLE);
    check("ah_idle_send", outSend,  1'b0);
    inAck = 1'b0;
    tick();
    serve_one("ah");

    // reset during SEND with three words queued and the error flag set
    write_word(16'h0101, 1'b1);
    write_word(16'h0202, 1'b1);
    write_word(16'h0303, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    check("rs_pre_err",   outErr,   1'b1);
    check("rs_pre_count", outCount, 3'd3);
    rstPER = 1'b0;
    tick();
    exp_q.delete();
    check("rs_send",  outSend,  1'b0);
    check("rs_count", outCount, 3'd0);
    check("rs_data",  outData,  16'h0000);
    check("rs_ovf",   outOvf,   1'b0);
    check("rs_err",   outErr,   1'b0);
    check("rs_state", dbgState, S_IDLE);
    rstPER = 1'b1;
    tick();
    check("rs_quiet", outSend, 1'b0);
    write_word(16'h0777, 1'b1);
    tick();
    serve_one("post");
    check("post_empty", outCount, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
